// File: rtl/pingpong_tile_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_tile_buffer_if : producer / PE-side bundle for the ping-pong buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pingpong_tile_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  logic                      flush;
  logic                      wr_valid;
  logic [DATA_W*LANES-1:0]   wr_data;
  logic                      wr_ready;
  logic                      wr_swap;
  logic                      rd_en;
  logic                      rd_replay;
  logic                      rd_avail;
  logic [DATA_W*LANES-1:0]   rd_data;
  logic                      rd_valid;
  logic                      rd_last;
  logic                      rd_swap;
  logic [1:0]                tiles_full;

  modport master (
    output flush, wr_valid, wr_data, rd_en, rd_replay,
    input  wr_ready, wr_swap, rd_avail, rd_data, rd_valid, rd_last, rd_swap, tiles_full
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_en, rd_replay,
    output wr_ready, wr_swap, rd_avail, rd_data, rd_valid, rd_last, rd_swap, tiles_full
  );
endinterface
`default_nettype wire

// File: rtl/pingpong_tile_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_tile_buffer : two-bank tile buffer with auto hand-off and replay
// Revision: 1.0
// ---------------------------------------------------------------------------
module pingpong_tile_buffer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pingpong_tile_buffer_if.slave  bus
);
  localparam int WORD_W = DATA_W * LANES;
  localparam int CW     = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t       state   [2];
  bank_state_t       state_n [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [WORD_W-1:0] mem [2][DEPTH];

  logic clear;
  logic wr_fire;
  logic rd_fire;
  logic wr_end;
  logic rd_end;
  logic [1:0] full_n;

  assign clear        = rst || bus.flush;
  assign bus.wr_ready = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
  assign bus.rd_avail = (state[rd_bank] == FULL)  || (state[rd_bank] == DRAINING);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign rd_fire      = bus.rd_en && bus.rd_avail;
  assign wr_end       = wr_fire && (wr_cnt == LAST);
  assign rd_end       = rd_fire && (rd_cnt == LAST);

  // A bank is never writable and readable at once, so both fires may update
  // state_n in the same cycle without colliding.
  always_comb begin
    state_n[0] = state[0];
    state_n[1] = state[1];
    if (wr_fire) begin
      state_n[wr_bank] = wr_end ? FULL : FILLING;
    end
    if (rd_fire) begin
      if (rd_end) begin
        state_n[rd_bank] = bus.rd_replay ? FULL : EMPTY;
      end else begin
        state_n[rd_bank] = DRAINING;
      end
    end
    full_n = 2'((state_n[0] == FULL) ? 1 : 0) + 2'((state_n[1] == FULL) ? 1 : 0);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state[0]       <= EMPTY;
      state[1]       <= EMPTY;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      bus.wr_swap    <= 1'b0;
      bus.rd_data    <= '0;
      bus.rd_valid   <= 1'b0;
      bus.rd_last    <= 1'b0;
      bus.rd_swap    <= 1'b0;
      bus.tiles_full <= 2'd0;
    end else begin
      state[0]       <= state_n[0];
      state[1]       <= state_n[1];
      bus.tiles_full <= full_n;
      bus.wr_swap    <= wr_end;
      bus.rd_valid   <= rd_fire;
      bus.rd_last    <= rd_end;
      bus.rd_swap    <= rd_end && !bus.rd_replay;
      if (wr_fire) begin
        wr_cnt <= wr_end ? '0 : wr_cnt + CW'(1);
      end
      if (wr_end) begin
        wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        bus.rd_data <= mem[rd_bank][rd_cnt];
        rd_cnt      <= rd_end ? '0 : rd_cnt + CW'(1);
      end
      if (rd_end && !bus.rd_replay) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Storage has no reset: flush only forgets which tiles are resident.
  always_ff @(posedge clk) begin
    if (wr_fire && !clear) begin
      mem[wr_bank][wr_cnt] <= bus.wr_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pingpong_tile_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pingpong_tile_buffer : directed self-checking bench for the tile buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pingpong_tile_buffer;
  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pingpong_tile_buffer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  pingpong_tile_buffer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_wr_ready"},   32'(bus.wr_ready),   32'd1);
    chk({pfx, "_wr_swap"},    32'(bus.wr_swap),    32'd0);
    chk({pfx, "_rd_avail"},   32'(bus.rd_avail),   32'd0);
    chk({pfx, "_rd_data"},    bus.rd_data,         32'd0);
    chk({pfx, "_rd_valid"},   32'(bus.rd_valid),   32'd0);
    chk({pfx, "_rd_last"},    32'(bus.rd_last),    32'd0);
    chk({pfx, "_rd_swap"},    32'(bus.rd_swap),    32'd0);
    chk({pfx, "_tiles_full"}, 32'(bus.tiles_full), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_replay = 1'b0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // Fill one tile 0..15 into bank 0.
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(i);
      step();
      chk("fill_swap",  32'(bus.wr_swap),  32'(i == DEPTH - 1));
      chk("fill_avail", 32'(bus.rd_avail), 32'(i == DEPTH - 1));
      chk("fill_ready", 32'(bus.wr_ready), 32'd1);
    end
    chk("fill_tiles_full", 32'(bus.tiles_full), 32'd1);
    bus.wr_valid = 1'b0;
    step();
    chk("fill_swap_width", 32'(bus.wr_swap), 32'd0);
    chk("fill_no_valid",   32'(bus.rd_valid), 32'd0);

    // Stream: write 16..47 while reading 0..47 back to back.
    for (int c = 0; c < 3 * DEPTH; c++) begin
      bus.rd_en    = 1'b1;
      bus.wr_valid = (c < 2 * DEPTH);
      bus.wr_data  = 32'(16 + c);
      step();
      chk("stream_valid",   32'(bus.rd_valid), 32'd1);
      chk("stream_data",    bus.rd_data,       32'(c));
      chk("stream_last",    32'(bus.rd_last),  32'(c % DEPTH == DEPTH - 1));
      chk("stream_rd_swap", 32'(bus.rd_swap),  32'(c % DEPTH == DEPTH - 1));
      chk("stream_wr_swap", 32'(bus.wr_swap),  32'(c == 15 || c == 31));
    end
    bus.rd_en    = 1'b0;
    bus.wr_valid = 1'b0;
    step();
    chk("stream_end_valid", 32'(bus.rd_valid),   32'd0);
    chk("stream_end_avail", 32'(bus.rd_avail),   32'd0);
    chk("stream_end_full",  32'(bus.tiles_full), 32'd0);

    // Fill two tiles 100..131 with no reads.
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(100 + i);
      step();
      chk("dual_wr_swap", 32'(bus.wr_swap), 32'(i == 15 || i == 31));
    end
    chk("dual_tiles_full", 32'(bus.tiles_full), 32'd2);
    chk("dual_wr_ready",   32'(bus.wr_ready),   32'd0);
    bus.wr_data = 32'd132;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wr_ready", 32'(bus.wr_ready),   32'd0);
      chk("stall_full",     32'(bus.tiles_full), 32'd2);
    end
    // Drain both tiles; the stalled word 132 enters only after the rd_swap.
    for (int c = 0; c < 2 * DEPTH; c++) begin
      bus.rd_en    = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = (c < DEPTH) ? 32'd132 : 32'(132 + c - DEPTH);
      step();
      chk("dual_rd_data",  bus.rd_data,       32'(100 + c));
      chk("dual_wr_ready", 32'(bus.wr_ready), 32'(c >= 15));
      chk("dual_wr_swap2", 32'(bus.wr_swap),  32'(c == 31));
      chk("dual_rd_swap",  32'(bus.rd_swap),  32'(c == 15 || c == 31));
      if (c == 15) chk("dual_full_mid", 32'(bus.tiles_full), 32'd1);
    end
    bus.wr_valid = 1'b0;

    // Replay: tile 132..147 read twice, released only on the second pass.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < DEPTH; c++) begin
        bus.rd_en     = 1'b1;
        bus.rd_replay = (p == 0 && c == DEPTH - 1);
        step();
        chk("replay_data",  bus.rd_data,       32'(132 + c));
        chk("replay_last",  32'(bus.rd_last),  32'(c == DEPTH - 1));
        chk("replay_swap",  32'(bus.rd_swap),  32'(p == 1 && c == DEPTH - 1));
        chk("replay_avail", 32'(bus.rd_avail), 32'(!(p == 1 && c == DEPTH - 1)));
        if (p == 0 && c == 0)         chk("replay_full_drain", 32'(bus.tiles_full), 32'd0);
        if (p == 0 && c == DEPTH - 1) chk("replay_full_back",  32'(bus.tiles_full), 32'd1);
      end
    end
    bus.rd_replay = 1'b0;

    // Reads with nothing available are ignored.
    for (int i = 0; i < 2; i++) begin
      bus.rd_en = 1'b1;
      step();
      chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("idle_rd_avail", 32'(bus.rd_avail), 32'd0);
    end
    bus.rd_en = 1'b0;

    // One full tile plus 7 words of a partial tile, then flush.
    for (int i = 0; i < DEPTH + 7; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(200 + i);
      step();
      chk("preflush_wr_swap", 32'(bus.wr_swap), 32'(i == DEPTH - 1));
    end
    chk("preflush_full", 32'(bus.tiles_full), 32'd1);
    bus.wr_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    chk_reset("flush");
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'(300 + i);
      step();
      chk("postflush_wr_swap", 32'(bus.wr_swap),  32'(i == DEPTH - 1));
      chk("postflush_rd_swap", 32'(bus.rd_swap),  32'd0);
    end
    bus.wr_valid = 1'b0;
    chk("postflush_avail", 32'(bus.rd_avail), 32'd1);

    // Partial drain, then reset while a read is being accepted.
    for (int c = 0; c < 6; c++) begin
      bus.rd_en = 1'b1;
      step();
      chk("postflush_rd_data", bus.rd_data, 32'(300 + c));
    end
    rst = 1'b1;
    step();
    chk_reset("rst_mid");
    rst = 1'b0;
    step();
    chk("after_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("after_rst_rd_avail", 32'(bus.rd_avail), 32'd0);
    bus.rd_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
